// File: rtl/imm_encoder.sv
// RV32I instruction packer: fields + immediate -> 32-bit word, two-stage valid/ready
// pipeline with immediate range checking, sequential byte addressing and an error counter.
module imm_encoder #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic        s1_v;
    logic [31:0] s1_instr;
    logic        s1_err;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        s2_adv;
    logic        accept;
    logic        out_fire;

    // An immediate fits signed N bits when bits [31:N-1] are all copies of the sign.
    assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
        case (in_opcode)
            OP_JAL: begin
                enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_err   = ~fits21 | in_imm[0];
            end
            OP_LOAD, OP_IMM, OP_JALR: begin
                enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err   = ~fits12;
            end
            OP_STORE: begin
                enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err   = ~fits12;
            end
            OP_BRANCH: begin
                enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                enc_err   = ~fits13 | in_imm[0];
            end
            default: begin
                enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_err   = 1'b0;
            end
        endcase
    end

    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = (~s1_v | s2_adv) & ~clear;
    assign accept   = in_valid & in_ready;
    // A handshake coinciding with clear is dropped, so it must not move the address or count.
    assign out_fire = out_valid & out_ready & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_instr <= '0;
            s1_err   <= 1'b0;
        end else if (clear) begin
            s1_v <= 1'b0;
        end else if (~s1_v | s2_adv) begin
            s1_v <= accept;
            if (accept) begin
                s1_instr <= enc_instr;
                s1_err   <= enc_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_instr <= s1_instr;
                out_err   <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr  <= BASE;
            err_count <= '0;
        end else if (clear) begin
            out_addr  <= BASE;
            err_count <= '0;
        end else if (out_fire) begin
            out_addr <= out_addr + ADDR_W'(4);
            if (out_err && !(&err_count)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: table of known encodings, randomized stream against a
// scoreboard model, plus clear, saturation, address-wrap and async-reset sequences.
module tb_imm_encoder;

    localparam int          ADDR_W    = 8;
    localparam int          ERR_W     = 4;
    localparam logic [31:0] BASE_ADDR = 32'hFC;
    localparam logic [7:0]  BASE8     = 8'hFC;
    localparam int          ERR_MAX   = 15;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [ERR_W-1:0]  err_count;

    imm_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    int          tests_run    = 0;
    int          tests_failed = 0;
    exp_t        exp_q[$];
    logic [7:0]  model_addr   = BASE8;
    int          model_errc   = 0;
    bit          prev_stall   = 0;
    logic [31:0] held_instr;
    logic [7:0]  held_addr;
    logic        held_err;
    bit          last_acc;
    logic        seen_ov;
    logic [31:0] seen_instr;
    logic        seen_err;
    logic [7:0]  seen_addr;
    vec_t        tbl[12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference encoding built from the field placement rules with shifts and masks.
    function automatic exp_t refEncode(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [6:0] f7, input logic [31:0] imm);
        exp_t   r;
        longint s;
        s = longint'($signed(imm));
        r.err = 1'b0;
        case (op)
            7'b1101111: begin
                r.instr = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                        | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                        | (32'(rd) << 7) | 32'(op);
                r.err = (s < -1048576) || (s > 1048575) || (imm[0] == 1'b1);
            end
            7'b0000011, 7'b0010011, 7'b1100111: begin
                r.instr = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                        | (32'(rd) << 7) | 32'(op);
                r.err = (s < -2048) || (s > 2047);
            end
            7'b0100011: begin
                r.instr = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                        | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
                r.err = (s < -2048) || (s > 2047);
            end
            7'b1100011: begin
                r.instr = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                        | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                        | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
                r.err = (s < -4096) || (s > 4095) || (imm[0] == 1'b1);
            end
            default: begin
                r.instr = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                        | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
            end
        endcase
        return r;
    endfunction

    // One clock: observe at the falling edge, update the scoreboard, return just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc   = 0;
        seen_ov    = out_valid;
        seen_instr = out_instr;
        seen_err   = out_err;
        seen_addr  = out_addr;
        if (!rst_n) begin
            exp_q.delete();
            model_addr = BASE8;
            model_errc = 0;
            prev_stall = 0;
        end else if (clear) begin
            checkOutput("in_ready_during_clear", 32'(in_ready), 32'd0);
            exp_q.delete();
            model_addr = BASE8;
            model_errc = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_instr", out_instr, held_instr);
                checkOutput("stall_err", 32'(out_err), 32'(held_err));
                checkOutput("stall_addr", 32'(out_addr), 32'(held_addr));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_word: got %h expected no word", out_instr);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_instr", out_instr, e.instr);
                    checkOutput("sb_err", 32'(out_err), 32'(e.err));
                    checkOutput("sb_addr", 32'(out_addr), 32'(model_addr));
                    checkOutput("sb_err_count", 32'(err_count), 32'(model_errc));
                    model_addr = model_addr + 8'd4;
                    if (e.err && model_errc < ERR_MAX) model_errc++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(refEncode(in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm));
                last_acc = 1;
            end
            prev_stall = out_valid && !out_ready;
            held_instr = out_instr;
            held_addr  = out_addr;
            held_err   = out_err;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setFields(input vec_t v);
        in_opcode = v.op;
        in_rd     = v.rd;
        in_funct3 = v.f3;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    task automatic randFields();
        logic [6:0] ops[8];
        int         mode;
        ops = '{7'h6F, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h33, 7'h37};
        in_opcode = ops[$urandom_range(0, 7)];
        in_rd     = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_funct7 = 7'($urandom);
        mode      = $urandom_range(0, 3);
        case (mode)
            0: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1: in_imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
            2: in_imm = $urandom;
            default: in_imm = (32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000) & 32'hFFFF_FFFE;
        endcase
    endtask

    // Single word through an empty pipeline with out_ready high: accept, 2-cycle latency, check fields.
    task automatic applyStimulus(input vec_t v, input logic [7:0] exp_addr, input int idx);
        int n;
        setFields(v);
        in_valid = 1'b1;
        n = 0;
        last_acc = 0;
        while (!last_acc && n < 10) begin
            tick();
            n++;
        end
        if (!last_acc) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout vec %0d: got no accept required accept", idx);
        end
        in_valid = 1'b0;
        tick();
        checkOutput($sformatf("latency_early_%0d", idx), 32'(seen_ov), 32'd0);
        tick();
        checkOutput($sformatf("latency_valid_%0d", idx), 32'(seen_ov), 32'd1);
        checkOutput($sformatf("tbl_instr_%0d", idx), seen_instr, v.exp_instr);
        checkOutput($sformatf("tbl_err_%0d", idx), 32'(seen_err), 32'(v.exp_err));
        checkOutput($sformatf("tbl_addr_%0d", idx), 32'(seen_addr), 32'(exp_addr));
    endtask

    task automatic drain(input string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   acc;
        int   n;
        vec_t errw;

        tbl[0]  = '{7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
        tbl[1]  = '{7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0008, 32'h0080_00EF, 1'b0};
        tbl[2]  = '{7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'h0000_0004, 32'h0020_A223, 1'b0};
        tbl[3]  = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        tbl[4]  = '{7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0800, 32'h8000_0093, 1'b1};
        tbl[5]  = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0000_0003, 32'h0000_0163, 1'b1};
        tbl[6]  = '{7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0};
        tbl[7]  = '{7'h33, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20, 32'h0000_0000, 32'h4073_02B3, 1'b0};
        tbl[8]  = '{7'h03, 5'd5, 3'd2, 5'd6, 5'd0, 7'h00, 32'hFFFF_F800, 32'h8003_2283, 1'b0};
        tbl[9]  = '{7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0010_0000, 32'h8000_006F, 1'b1};
        tbl[10] = '{7'h67, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00, 32'h0000_07FF, 32'h7FF1_00E7, 1'b0};
        tbl[11] = '{7'h23, 5'd0, 3'd0, 5'd4, 5'd3, 7'h00, 32'hFFFF_F7FF, 32'h7E32_0FA3, 1'b1};
        errw    = tbl[4];

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        setFields(tbl[0]);
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_out_addr", 32'(out_addr), 32'(BASE8));
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        // Known encodings; addresses start at FC and wrap to 00.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], BASE8 + 8'(4 * i), i);
        end
        checkOutput("tbl_err_count", 32'(err_count), 32'd4);

        // Back-to-back: four accepts in four cycles, addresses restart from FC after clear.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 4 && n < 20) begin
            setFields(tbl[acc]);
            tick();
            n++;
            if (last_acc) acc++;
        end
        checkOutput("b2b_cycles", 32'(n), 32'd4);
        drain("b2b_drain");
        checkOutput("b2b_final_addr", 32'(out_addr), 32'h0C);

        // Random stream with random backpressure.
        acc = 0;
        n = 0;
        randFields();
        while (acc < 40 && n < 1000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            tick();
            n++;
            if (last_acc) begin
                acc++;
                randFields();
            end
        end
        checkOutput("rand_accepted", 32'(acc), 32'd40);
        drain("rand_drain");

        // Clear with a full pipeline, an input offer and an output handshake in the same cycle.
        out_ready = 1'b1;
        applyStimulus(errw, model_addr, 100);
        checkOutput("pre_clear_err_count", 32'(err_count), 32'(model_errc));
        out_ready = 1'b0;
        setFields(errw);
        in_valid = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 2 && n < 10) begin
            tick();
            n++;
            if (last_acc) acc++;
        end
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        clear = 1'b1;
        out_ready = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        checkOutput("clear_out_valid", 32'(out_valid), 32'd0);
        checkOutput("clear_out_addr", 32'(out_addr), 32'(BASE8));
        checkOutput("clear_err_count", 32'(err_count), 32'd0);
        tick();
        checkOutput("clear_s1_flushed", 32'(seen_ov), 32'd0);

        // Error counter saturation.
        setFields(errw);
        in_valid = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 18 && n < 60) begin
            tick();
            n++;
            if (last_acc) acc++;
        end
        drain("sat_drain");
        checkOutput("sat_err_count", 32'(err_count), 32'(ERR_MAX));

        // Asynchronous reset in the middle of a stalled stream.
        out_ready = 1'b0;
        setFields(tbl[1]);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_out_instr", out_instr, 32'd0);
        checkOutput("mid_rst_out_err", 32'(out_err), 32'd0);
        checkOutput("mid_rst_out_addr", 32'(out_addr), 32'(BASE8));
        checkOutput("mid_rst_err_count", 32'(err_count), 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("post_rst_valid_a", 32'(seen_ov), 32'd0);
        tick();
        checkOutput("post_rst_valid_b", 32'(seen_ov), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
